// File: rtl/fpu_int_pkg.sv
// Shared constants and state encodings for the FPU integer units (squarer side).
package fpu_int_pkg;

  localparam int unsigned SQ_RW = 35;
  localparam int unsigned SQ_VW = 2 * SQ_RW;

  localparam logic [1:0] SQ_IDLE = 2'd0;
  localparam logic [1:0] SQ_MUL  = 2'd1;
  localparam logic [1:0] SQ_FIN  = 2'd2;

endpackage

// File: rtl/square_int.sv
// Multi-cycle radix-2 shift-add integer squarer returning root^2 (plus rem when the
// SQUARE_REM_EN macro is defined, reconstructing a square-root radicand).
module square_int
  import fpu_int_pkg::*;
#(
  parameter int unsigned RW = SQ_RW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [RW-1:0]   root,
`ifdef SQUARE_REM_EN
  input  logic [RW:0]     rem,
  output logic            rem_bad,
`endif
  output logic [2*RW-1:0] value,
  output logic            busy,
  output logic            done
);

  localparam int unsigned VW = 2 * RW;

  logic [1:0]    state_q, state_d;
  logic [VW-1:0] mcand_q;
  logic [RW-1:0] mplier_q;
  logic [RW-1:0] mplier_shr;
  logic [VW-1:0] acc_q;
  logic [VW-1:0] value_q;
  logic          done_q;
  logic [VW-1:0] addend;
  logic [VW-1:0] sum;

`ifdef SQUARE_REM_EN
  logic [RW:0]   rem_q;
  logic          rem_bad_pend_q;
  logic          rem_bad_q;
`endif

  assign mplier_shr = mplier_q >> 1;

  // Single adder: partial products during MUL, remainder (or zero) during FIN.
  always_comb begin
    addend = '0;
    if (state_q == SQ_MUL) begin
      addend = mcand_q;
    end else begin
`ifdef SQUARE_REM_EN
      addend = {{(VW-RW-1){1'b0}}, rem_q};
`else
      addend = '0;
`endif
    end
    sum = acc_q + addend;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SQ_IDLE: if (enable)             state_d = SQ_MUL;
      SQ_MUL:  if (mplier_shr == '0)   state_d = SQ_FIN;
      SQ_FIN:                          state_d = SQ_IDLE;
      default:                         state_d = SQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= SQ_IDLE;
      mcand_q        <= '0;
      mplier_q       <= '0;
      acc_q          <= '0;
      value_q        <= '0;
      done_q         <= 1'b0;
`ifdef SQUARE_REM_EN
      rem_q          <= '0;
      rem_bad_pend_q <= 1'b0;
      rem_bad_q      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        SQ_IDLE: begin
          if (enable) begin
            mcand_q  <= {{RW{1'b0}}, root};
            mplier_q <= root;
            acc_q    <= '0;
`ifdef SQUARE_REM_EN
            rem_q          <= rem;
            rem_bad_pend_q <= (rem > {root, 1'b0});
`endif
          end
        end
        SQ_MUL: begin
          if (mplier_q[0]) acc_q <= sum;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_shr;
        end
        SQ_FIN: begin
          value_q <= sum;
          done_q  <= 1'b1;
`ifdef SQUARE_REM_EN
          rem_bad_q <= rem_bad_pend_q;
`endif
        end
        default: ;
      endcase
    end
  end

  assign value = value_q;
  assign done  = done_q;
  assign busy  = (state_q != SQ_IDLE);
`ifdef SQUARE_REM_EN
  assign rem_bad = rem_bad_q;
`endif

endmodule

// File: tb/tb_square_int.sv
// Scoreboard bench for square_int: randomized ops checked against an arithmetic model;
// covers the SQUARE_REM_EN build when that macro is defined.
module tb_square_int;

  localparam int RW = 35;
  localparam int VW = 70;

  typedef struct packed {
    logic [VW-1:0] val;
    logic          bad;
    int unsigned   cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [RW-1:0] root = '0;
  logic [RW:0]   rem_drv = '0;
  logic [VW-1:0] value;
  logic          busy;
  logic          done;
`ifdef SQUARE_REM_EN
  logic          rem_bad;
`endif

  exp_t          q[$];
  int unsigned   cyc = 0;
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [VW-1:0] last_val = '0;

  square_int #(.RW(RW)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .root   (root),
`ifdef SQUARE_REM_EN
    .rem    (rem_drv),
    .rem_bad(rem_bad),
`endif
    .value  (value),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Number of MUL iterations: position of the root MSB plus one, minimum one.
  function automatic int unsigned lat_k(input logic [RW-1:0] r);
    int unsigned k = 1;
    for (int i = 0; i < RW; i++) if (r[i]) k = i + 1;
    return k;
  endfunction

  function automatic logic [RW-1:0] rand_root();
    logic [63:0] x;
    x = {$urandom, $urandom};
    if ($urandom_range(0, 15) == 0) return '0;
    return x[RW-1:0] >> $urandom_range(0, RW - 1);
  endfunction

  function automatic logic [RW:0] rand_rem(input logic [RW-1:0] r);
    logic [63:0] x;
    x = {$urandom, $urandom};
    if ($urandom_range(0, 1) == 0) return {r, 1'b0} + RW'($urandom_range(0, 1));
    return x[RW:0];
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Drive one cycle of inputs; if the DUT will accept, record what it must produce.
  task automatic apply(input logic en, input logic [RW-1:0] r, input logic [RW:0] rm);
    exp_t e;
    logic [VW-1:0] rv;
    enable  = en;
    root    = r;
    rem_drv = rm;
    if (en && !busy && !reset) begin
      rv    = {{RW{1'b0}}, r};
      e.val = rv * rv;
      e.bad = 1'b0;
`ifdef SQUARE_REM_EN
      e.val = e.val + {{(VW-RW-1){1'b0}}, rm};
      e.bad = ({1'b0, rm} > {1'b0, r, 1'b0});
`endif
      e.cyc = cyc + 2 + lat_k(r);
      q.push_back(e);
    end
  endtask

  task automatic single(input logic [RW-1:0] r, input logic [RW:0] rm);
    int budget;
    apply(1'b1, r, rm);
    step();
    apply(1'b0, '0, '0);
    budget = 0;
    while (busy && budget < 100) begin
      step();
      budget++;
    end
    step();
  endtask

  // Monitor: compares every completion against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        check("reset_busy", {69'd0, busy}, '0);
        check("reset_done", {69'd0, done}, '0);
        check("reset_value", value, '0);
`ifdef SQUARE_REM_EN
        check("reset_rem_bad", {69'd0, rem_bad}, '0);
`endif
        last_val = '0;
      end else if (done) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got done=1 expected no completion (cycle %0d)", cyc);
        end else begin
          e = q.pop_front();
          check("value", value, e.val);
          check("done_cycle", VW'(cyc), VW'(e.cyc));
`ifdef SQUARE_REM_EN
          check("rem_bad", {69'd0, rem_bad}, {69'd0, e.bad});
`endif
          last_val = e.val;
        end
      end else begin
        check("value_hold", value, last_val);
      end
    end
  end

  initial begin
    int budget;
    logic [RW-1:0] r;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;

    // root = 0: busy for exactly two cycles after accept.
    apply(1'b1, '0, '0);
    step();
    apply(1'b0, '0, '0);
    check("r0_busy_1", {69'd0, busy}, 70'd1);
    step();
    check("r0_busy_2", {69'd0, busy}, 70'd1);
    step();
    check("r0_busy_3", {69'd0, busy}, 70'd0);
    step();

    single(35'd3, '0);
    single(35'h4_0000_0000, '0);
    single(35'h7_FFFF_FFFF, '0);
`ifdef SQUARE_REM_EN
    single(35'd5, 36'd10);
    single(35'd5, 36'd11);
    // Round trip: integer sqrt of a random radicand, then back through the squarer.
    for (int n = 0; n < 20; n++) begin
      logic [VW-1:0] rad, t;
      logic [RW-1:0] res;
      rad = {6'($urandom), $urandom, $urandom} >> $urandom_range(0, VW - 1);
      res = '0;
      for (int i = RW - 1; i >= 0; i--) begin
        r = res | (RW'(1) << i);
        t = {{RW{1'b0}}, r} * {{RW{1'b0}}, r};
        if (t <= rad) res = r;
      end
      t = rad - {{RW{1'b0}}, res} * {{RW{1'b0}}, res};
      single(res, t[RW:0]);
    end
`endif

    // Random traffic, including enable pulses while busy.
    repeat (3000) begin
      r = rand_root();
      apply(($urandom_range(0, 3) == 0), r, rand_rem(r));
      step();
    end

    // Enable held continuously: back-to-back operations.
    repeat (400) begin
      r = rand_root();
      apply(1'b1, r, rand_rem(r));
      step();
    end
    apply(1'b0, '0, '0);

    // Reset in the middle of a long MUL phase.
    budget = 0;
    while (busy && budget < 100) begin
      step();
      budget++;
    end
    step();
    apply(1'b1, 35'h7_FFFF_FFFF, '0);
    step();
    apply(1'b0, '0, '0);
    repeat (5) step();
    reset = 1'b1;
    q.delete();
    step();
    reset = 1'b0;
    single(35'd3, 36'd1);
    single(35'h1234_5678, '0);

    budget = 0;
    while (q.size() != 0 && budget < 100) begin
      step();
      budget++;
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending results expected 0", q.size());
    end
    repeat (5) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
